// File: rtl/tia_pkg.sv
// Shared constants and helpers for the TIA horizontal timing stage.
// The polynomial step rule lives here so decode constants fold at elaboration.
package tia_pkg;

  localparam int HLEN = 57;
  localparam int W    = 6;

  localparam int IDX_SHB  = 0;
  localparam int IDX_SHS  = 4;
  localparam int IDX_RHS  = 8;
  localparam int IDX_RCB  = 12;
  localparam int IDX_RHB  = 16;
  localparam int IDX_LRHB = 18;
  localparam int IDX_CNT  = 36;

  localparam logic [W-1:0] HPOLY_LOCK = 6'b111111;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } hphase_e;

  typedef enum logic [1:0] {
    NX_STEP = 2'd0,
    NX_WRAP = 2'd1,
    NX_LOCK = 2'd2,
    NX_SYNC = 2'd3
  } hnext_e;

  function automatic logic [W-1:0] hpoly_step(
    input logic [W-1:0] v
  );
    return {v[W-2:0], ~(v[W-1] ^ v[W-2])};
  endfunction

  function automatic logic [W-1:0] hpoly_at(
    input int n
  );
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      v = hpoly_step(v);
    end
    return v;
  endfunction

endpackage

// File: rtl/tia_hphase.sv
// Two-phase strobe generator: divides the colour clock by four.
// Strobes are registered so tia_dl sees glitch-free s1/s2.
module tia_hphase
  import tia_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  output logic o_hphi1,
  output logic o_hphi2,
  output logic o_step
);

  hphase_e r_ph;
  hphase_e w_ph_nxt;
  logic    r_hphi1;
  logic    r_hphi2;

  assign w_ph_nxt = hphase_e'(r_ph + 2'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ph    <= PH0;
      r_hphi1 <= 1'b0;
      r_hphi2 <= 1'b0;
    end else begin
      r_ph    <= w_ph_nxt;
      r_hphi1 <= (w_ph_nxt == PH1);
      r_hphi2 <= (w_ph_nxt == PH3);
    end
  end

  // The 3->0 edge is the only edge the counter may move on.
  assign o_step  = (r_ph == PH3);
  assign o_hphi1 = r_hphi1;
  assign o_hphi2 = r_hphi2;

endmodule

// File: rtl/tia_hcount.sv
// TIA horizontal polynomial counter with RSYNC and HBLANK/HSYNC decodes.
// Feeds the tia_dl latches: decodes hold steady across a whole phase window.
module tia_hcount
  import tia_pkg::*;
(
  input  logic         clk,
  input  logic         r,
  input  logic         rsync,
  output logic         hphi1,
  output logic         hphi2,
  output logic [W-1:0] hcount,
  output logic         line_end,
  output logic         d_shb,
  output logic         d_shs,
  output logic         d_rhs,
  output logic         d_rcb,
  output logic         d_rhb,
  output logic         d_lrhb,
  output logic         d_cnt
);

  localparam logic [W-1:0] HP_SHB  = hpoly_at(IDX_SHB);
  localparam logic [W-1:0] HP_SHS  = hpoly_at(IDX_SHS);
  localparam logic [W-1:0] HP_RHS  = hpoly_at(IDX_RHS);
  localparam logic [W-1:0] HP_RCB  = hpoly_at(IDX_RCB);
  localparam logic [W-1:0] HP_RHB  = hpoly_at(IDX_RHB);
  localparam logic [W-1:0] HP_LRHB = hpoly_at(IDX_LRHB);
  localparam logic [W-1:0] HP_CNT  = hpoly_at(IDX_CNT);
  localparam logic [W-1:0] HP_END  = hpoly_at(HLEN - 1);

  logic         w_step;
  logic [W-1:0] r_hcount;
  logic         r_pend;
  logic         r_line_end;
  hnext_e       w_sel;
  logic [W-1:0] w_nxt;

  tia_hphase u_hphase (
    .i_clk   (clk),
    .i_rst   (r),
    .o_hphi1 (hphi1),
    .o_hphi2 (hphi2),
    .o_step  (w_step)
  );

  // A live rsync on the step edge counts the same as a pending one.
  always_comb begin
    w_sel = NX_STEP;
    priority case (1'b1)
      (rsync | r_pend):          w_sel = NX_SYNC;
      (r_hcount == HPOLY_LOCK):  w_sel = NX_LOCK;
      (r_hcount == HP_END):      w_sel = NX_WRAP;
      default:                   w_sel = NX_STEP;
    endcase
  end

  always_comb begin
    w_nxt = '0;
    unique case (w_sel)
      NX_STEP: w_nxt = hpoly_step(r_hcount);
      NX_WRAP: w_nxt = '0;
      NX_LOCK: w_nxt = '0;
      NX_SYNC: w_nxt = '0;
      default: w_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_hcount   <= '0;
      r_pend     <= 1'b0;
      r_line_end <= 1'b0;
    end else begin
      r_line_end <= w_step && (w_sel == NX_WRAP);
      if (w_step) begin
        r_hcount <= w_nxt;
        r_pend   <= 1'b0;
      end else if (rsync) begin
        r_pend   <= 1'b1;
      end
    end
  end

  assign hcount   = r_hcount;
  assign line_end = r_line_end;

  assign d_shb  = (r_hcount == HP_SHB);
  assign d_shs  = (r_hcount == HP_SHS);
  assign d_rhs  = (r_hcount == HP_RHS);
  assign d_rcb  = (r_hcount == HP_RCB);
  assign d_rhb  = (r_hcount == HP_RHB);
  assign d_lrhb = (r_hcount == HP_LRHB);
  assign d_cnt  = (r_hcount == HP_CNT);

endmodule

// File: tb/tb_tia_hcount.sv
// Bench for tia_hcount: directed scenarios plus random RSYNC traffic
// checked against an index-level model of the scanline.
module tb_tia_hcount;

  localparam int LOCK = 99;

  logic       clk;
  logic       r;
  logic       rsync;
  logic       hphi1;
  logic       hphi2;
  logic [5:0] hcount;
  logic       line_end;
  logic       d_shb;
  logic       d_shs;
  logic       d_rhs;
  logic       d_rcb;
  logic       d_rhb;
  logic       d_lrhb;
  logic       d_cnt;

  int n_tests;
  int n_fail;

  logic [5:0] tbl [0:62];
  int m_ph;
  int m_idx;
  int m_pend;
  int m_le;

  tia_hcount dut (
    .clk      (clk),
    .r        (r),
    .rsync    (rsync),
    .hphi1    (hphi1),
    .hphi2    (hphi2),
    .hcount   (hcount),
    .line_end (line_end),
    .d_shb    (d_shb),
    .d_shs    (d_shs),
    .d_rhs    (d_rhs),
    .d_rcb    (d_rcb),
    .d_rhb    (d_rhb),
    .d_lrhb   (d_lrhb),
    .d_cnt    (d_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] obs_vec();
    return {hphi1, hphi2, line_end, hcount,
            d_shb, d_shs, d_rhs, d_rcb, d_rhb, d_lrhb, d_cnt};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [5:0] hc;
    hc = (m_idx == LOCK) ? 6'h3f : tbl[m_idx];
    return {m_ph == 1, m_ph == 3, m_le != 0, hc,
            m_idx == 0, m_idx == 4, m_idx == 8, m_idx == 12,
            m_idx == 16, m_idx == 18, m_idx == 36};
  endfunction

  task automatic model_edge(input logic rs);
    m_le = 0;
    if (m_ph == 3) begin
      if (rs || m_pend != 0) begin
        m_idx  = 0;
        m_pend = 0;
      end else if (m_idx == LOCK) begin
        m_idx = 0;
      end else if (m_idx == 56) begin
        m_idx = 0;
        m_le  = 1;
      end else begin
        m_idx = m_idx + 1;
      end
    end else if (rs) begin
      m_pend = 1;
    end
    m_ph = (m_ph + 1) % 4;
  endtask

  task automatic clk1(input logic rs);
    rsync = rs;
    @(posedge clk);
    model_edge(rs);
    @(negedge clk);
    rsync = 1'b0;
  endtask

  task automatic model_clear();
    m_ph   = 0;
    m_idx  = 0;
    m_pend = 0;
    m_le   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    r     = 1'b1;
    rsync = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    r = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    r = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (hcount !== 6'd0 || hphi1 !== 1'b0 || hphi2 !== 1'b0
        || line_end !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: hc=%b p1=%b p2=%b le=%b want 000000 0 0 0",
               hcount, hphi1, hphi2, line_end);
    end
    n_tests++;
    if ({d_shb, d_shs, d_rhs, d_rcb, d_rhb, d_lrhb, d_cnt} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_decodes: got %b want 1000000",
               {d_shb, d_shs, d_rhs, d_rcb, d_rhb, d_lrhb, d_cnt});
    end
    r = 1'b0;
    model_clear();
    repeat (50) clk1(1'b0);
    #2;
    r = 1'b1;
    #1;
    n_tests++;
    if (hcount !== 6'd0 || hphi1 !== 1'b0 || hphi2 !== 1'b0
        || line_end !== 1'b0 || d_shb !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: hc=%b p1=%b p2=%b le=%b shb=%b",
               hcount, hphi1, hphi2, line_end, d_shb);
    end
    do_reset();
  endtask

  task automatic test_phases();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      clk1(1'b0);
      n_tests++;
      if (hphi1 !== (k % 4 == 1) || hphi2 !== (k % 4 == 3)) begin
        n_fail++;
        $display("FAIL phase_c%0d: p1=%b p2=%b want %b %b",
                 k, hphi1, hphi2, k % 4 == 1, k % 4 == 3);
      end
      if (k == 4) begin
        n_tests++;
        if (hcount !== 6'b000001) begin
          n_fail++;
          $display("FAIL first_step: hc=%b want 000001", hcount);
        end
      end
    end
  endtask

  task automatic test_full_line();
    int le_n;
    int dn [7];
    int f_shs;
    int f_rhs;
    logic [6:0] dv;
    do_reset();
    le_n  = 0;
    f_shs = -1;
    f_rhs = -1;
    for (int i = 0; i < 7; i++) dn[i] = 0;
    for (int k = 1; k <= 228; k++) begin
      clk1(1'b0);
      dv = {d_shb, d_shs, d_rhs, d_rcb, d_rhb, d_lrhb, d_cnt};
      for (int i = 0; i < 7; i++) if (dv[6-i]) dn[i]++;
      if (line_end) le_n++;
      if (d_shs && f_shs < 0) f_shs = k;
      if (d_rhs && f_rhs < 0) f_rhs = k;
    end
    n_tests++;
    if (hcount !== 6'd0) begin
      n_fail++;
      $display("FAIL line_wrap: hc=%b want 000000", hcount);
    end
    n_tests++;
    if (le_n != 1) begin
      n_fail++;
      $display("FAIL line_end_count: got %0d want 1", le_n);
    end
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (dn[i] != 4) begin
        n_fail++;
        $display("FAIL decode_width_%0d: got %0d clk want 4", i, dn[i]);
      end
    end
    n_tests++;
    if (f_rhs - f_shs != 16) begin
      n_fail++;
      $display("FAIL shs_to_rhs: got %0d want 16", f_rhs - f_shs);
    end
  endtask

  task automatic test_rsync();
    do_reset();
    repeat (81) clk1(1'b0);
    clk1(1'b1);
    clk1(1'b0);
    n_tests++;
    if (hcount !== tbl[20]) begin
      n_fail++;
      $display("FAIL rsync_hold: hc=%b want %b", hcount, tbl[20]);
    end
    clk1(1'b0);
    n_tests++;
    if (hcount !== 6'd0 || line_end !== 1'b0 || d_shb !== 1'b1) begin
      n_fail++;
      $display("FAIL rsync_load: hc=%b le=%b shb=%b want 000000 0 1",
               hcount, line_end, d_shb);
    end
    repeat (4) clk1(1'b0);
    n_tests++;
    if (hcount !== tbl[1] || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL rsync_after: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_rsync_step();
    do_reset();
    repeat (83) clk1(1'b0);
    clk1(1'b1);
    n_tests++;
    if (hcount !== 6'd0 || line_end !== 1'b0) begin
      n_fail++;
      $display("FAIL rsync_step_load: hc=%b le=%b want 000000 0",
               hcount, line_end);
    end
    repeat (4) clk1(1'b0);
    n_tests++;
    if (hcount !== tbl[1]) begin
      n_fail++;
      $display("FAIL rsync_step_nopend: hc=%b want %b", hcount, tbl[1]);
    end
  endtask

  task automatic test_lockup();
    do_reset();
    repeat (8) clk1(1'b0);
    force dut.r_hcount = 6'h3f;
    #1;
    release dut.r_hcount;
    m_idx = LOCK;
    repeat (3) clk1(1'b0);
    n_tests++;
    if (hcount !== 6'h3f) begin
      n_fail++;
      $display("FAIL lock_hold: hc=%b want 111111", hcount);
    end
    clk1(1'b0);
    n_tests++;
    if (hcount !== 6'd0 || line_end !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL lock_recover: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic rs;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rs = ($urandom_range(0, 40) == 0);
      if (k % 500 == 250) rs = 1'b1;
      clk1(rs);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_c%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_dl();
    logic a;
    logic q;
    logic a_n;
    logic q_n;
    logic dl_r;
    do_reset();
    a    = 1'b0;
    q    = 1'b0;
    dl_r = 1'b0;
    for (int k = 1; k <= 61; k++) begin
      if (k == 61) dl_r = 1'b1;
      a_n = hphi1 ? d_shs : a;
      q_n = dl_r ? 1'b0 : ((hphi2 && a) ? 1'b1 : q);
      clk1(1'b0);
      a = a_n;
      q = q_n;
      if (k == 16 || k == 20 || k == 60 || k == 61) begin
        n_tests++;
        if (q !== (k == 20 || k == 60)) begin
          n_fail++;
          $display("FAIL dl_c%0d: out=%b want %b", k, q, k == 20 || k == 60);
        end
      end
    end
  endtask

  initial begin
    logic [5:0] v;
    n_tests = 0;
    n_fail  = 0;
    r       = 1'b1;
    rsync   = 1'b0;
    model_clear();
    v = 6'd0;
    for (int i = 0; i < 63; i++) begin
      tbl[i] = v;
      v = {v[4:0], ~(v[5] ^ v[4])};
    end
    test_reset();
    test_phases();
    test_full_line();
    test_rsync();
    test_rsync_step();
    test_lockup();
    test_dl();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
